sig_mag_adpt_ctrl: RTL and testbench
====================================

SIG_MAG_ADPT_CTRL -- requirements
Module: sig_mag_adpt_ctrl

Interface
REQ-001 Parameter WIDTH, default 14, sample width of the controlled sig/mag quantizer; thresholds are WIDTH-1 bits.
REQ-002 Parameter PER_W, default 32, width of the re-adaptation period counter.
REQ-003 Parameter TMO_W, default 24, width of the adaptation timeout counter.
REQ-004 Parameter SETTLE_CYC, default 4, cycles waited after adpt_ready before sampling por_out.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 resetn  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse, begin adaptation sequence.
REQ-008 stop  in  1  one-cycle pulse, abort to IDLE.
REQ-009 period_cyc  in  PER_W  cycles spent in LOCKED before automatic re-adaptation; 0 = never.
REQ-010 tmo_cyc  in  TMO_W  maximum cycles in ADAPT; 0 = no timeout.
REQ-011 manual_en  in  1  manual threshold mode request.
REQ-012 manual_thr  in  WIDTH-1  manual threshold value.
REQ-013 adpt_ready  in  1  quantizer adaptation-complete flag.
REQ-014 por_out  in  WIDTH-1  quantizer adapted threshold.
REQ-015 clr  out  1  quantizer clear strobe, one cycle per sequence.
REQ-016 por_manual  out  1  quantizer manual-threshold enable.
REQ-017 por_in  out  WIDTH-1  quantizer manual threshold.
REQ-018 thr_lat  out  WIDTH-1  last latched adapted threshold.
REQ-019 busy  out  1  high in CLEAR, ADAPT, SETTLE.
REQ-020 done  out  1  one-cycle pulse when thr_lat updates.
REQ-021 tmo_err  out  1  sticky timeout flag.
REQ-022 adpt_cnt  out  16  count of completed adaptations, wraps 0xFFFF->0.

Function
REQ-023 FSM states IDLE, CLEAR, ADAPT, SETTLE, LOCKED; all outputs registered.
REQ-024 IDLE: start -> CLEAR; start also clears tmo_err.
REQ-025 CLEAR: lasts exactly one cycle with clr=1; -> ADAPT; ADAPT timeout counter loaded to 0.
REQ-026 ADAPT: counter increments each cycle; adpt_ready=1 -> SETTLE; else counter reaches tmo_cyc (tmo_cyc!=0) -> tmo_err=1, -> IDLE.
REQ-027 adpt_ready is ignored in the CLEAR cycle and in the first ADAPT cycle (stale flag guard).
REQ-028 SETTLE: waits SETTLE_CYC cycles, then samples por_out into thr_lat, pulses done, increments adpt_cnt, -> LOCKED.
REQ-029 LOCKED: period counter increments from 0; reaching period_cyc (period_cyc!=0) -> CLEAR; start in LOCKED -> CLEAR immediately (forced re-adaptation).
REQ-030 stop in any state -> IDLE next cycle; stop has priority over start, timeout and period expiry in the same cycle; thr_lat and adpt_cnt retained.
REQ-031 start while busy is ignored.
REQ-032 por_manual = manual_en registered (1-cycle latency), independent of FSM state; por_in = manual_thr registered.
REQ-033 manual_en does not stop adaptation; thr_lat still updates.
REQ-034 period_cyc and tmo_cyc are sampled live; a value decreased below the running count expires on the next comparison (count >= limit).
REQ-035 clr never asserted outside CLEAR; done never asserted outside the SETTLE->LOCKED transition.

Reset
REQ-036 resetn=0 asynchronously forces IDLE and clr, por_manual, por_in, thr_lat, busy, done, tmo_err, adpt_cnt and all counters to 0.
REQ-037 Reset mid-sequence aborts without a clr pulse; first start after release runs a full sequence.

Verification
REQ-038 start, adpt_ready rises 50 cycles after clr, por_out=0x0123 -> one clr, done 50+SETTLE_CYC+1 cycles later, thr_lat=0x0123, adpt_cnt=1.
REQ-039 tmo_cyc=100, adpt_ready held 0 -> tmo_err=1 at cycle 100 of ADAPT, FSM IDLE, no done.
REQ-040 period_cyc=200 after lock -> clr re-asserted 200 cycles after done, adpt_cnt=2 after second lock.
REQ-041 start and stop same cycle in LOCKED -> IDLE, no clr, thr_lat unchanged.
REQ-042 manual_en=1, manual_thr=0x0400 -> por_manual=1, por_in=0x0400 one cycle later in every state.
REQ-043 resetn pulsed low during ADAPT -> all outputs 0 immediately; adpt_cnt 0xFFFF + one lock -> 0.

Source files
------------

// File: rtl/sig_mag_adpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sig_mag_adpt_ctrl
// Brief   : Clear / adapt / settle / lock sequencer for a sig-mag quantizer
//           threshold, with timeout, periodic re-adaptation and manual bypass.
// Rev     : 1.0
// ============================================================================
module sig_mag_adpt_ctrl #(
  parameter int WIDTH      = 14,
  parameter int PER_W      = 32,
  parameter int TMO_W      = 24,
  parameter int SETTLE_CYC = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               stop,
  input  logic [PER_W-1:0]   period_cyc,
  input  logic [TMO_W-1:0]   tmo_cyc,
  input  logic               manual_en,
  input  logic [WIDTH-2:0]   manual_thr,
  input  logic               adpt_ready,
  input  logic [WIDTH-2:0]   por_out,
  output logic               clr,
  output logic               por_manual,
  output logic [WIDTH-2:0]   por_in,
  output logic [WIDTH-2:0]   thr_lat,
  output logic               busy,
  output logic               done,
  output logic               tmo_err,
  output logic [15:0]        adpt_cnt
);

  localparam int                 c_set_w   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [c_set_w:0]   c_set_lim = (c_set_w + 1)'(SETTLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ADAPT  = 3'd2,
    S_SETTLE = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [TMO_W-1:0]    r_tmo_cnt;
  logic [PER_W-1:0]    r_per_cnt;
  logic [c_set_w-1:0]  r_set_cnt;
  logic                r_adapt_first;

  logic                r_clr;
  logic                r_por_manual;
  logic [WIDTH-2:0]    r_por_in;
  logic [WIDTH-2:0]    r_thr_lat;
  logic                r_busy;
  logic                r_done;
  logic                r_tmo_err;
  logic [15:0]         r_adpt_cnt;

  logic [TMO_W:0]      w_tmo_inc;
  logic [PER_W:0]      w_per_inc;
  logic [c_set_w:0]    w_set_inc;
  logic [TMO_W-1:0]    w_tmo_sat;
  logic [PER_W-1:0]    w_per_sat;
  logic                w_tmo_hit;
  logic                w_per_hit;
  logic                w_set_hit;
  logic                w_lock;
  logic                w_timeout;
  logic                w_start_acc;

  // Counters compare their next value so a limit of N expires on the Nth cycle;
  // limits are read live, so a lowered limit expires on the next comparison.
  assign w_tmo_inc = {1'b0, r_tmo_cnt} + (TMO_W + 1)'(1);
  assign w_per_inc = {1'b0, r_per_cnt} + (PER_W + 1)'(1);
  assign w_set_inc = {1'b0, r_set_cnt} + (c_set_w + 1)'(1);

  assign w_tmo_sat = w_tmo_inc[TMO_W] ? r_tmo_cnt : w_tmo_inc[TMO_W-1:0];
  assign w_per_sat = w_per_inc[PER_W] ? r_per_cnt : w_per_inc[PER_W-1:0];

  assign w_tmo_hit = (tmo_cyc != '0)    && (w_tmo_inc >= {1'b0, tmo_cyc});
  assign w_per_hit = (period_cyc != '0) && (w_per_inc >= {1'b0, period_cyc});
  assign w_set_hit = (w_set_inc >= c_set_lim);

  always_comb begin
    w_state_nxt = r_state;
    w_lock      = 1'b0;
    w_timeout   = 1'b0;
    w_start_acc = 1'b0;
    if (stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_CLEAR;
            w_start_acc = 1'b1;
          end
        end
        S_CLEAR: begin
          w_state_nxt = S_ADAPT;
        end
        S_ADAPT: begin
          // A ready flag left over from the previous run is not trusted until
          // the quantizer has had one full cycle after the clear.
          if (adpt_ready && !r_adapt_first) begin
            w_state_nxt = S_SETTLE;
          end else if (w_tmo_hit) begin
            w_state_nxt = S_IDLE;
            w_timeout   = 1'b1;
          end
        end
        S_SETTLE: begin
          if (w_set_hit) begin
            w_state_nxt = S_LOCKED;
            w_lock      = 1'b1;
          end
        end
        S_LOCKED: begin
          if (start || w_per_hit) begin
            w_state_nxt = S_CLEAR;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_tmo_cnt     <= '0;
      r_per_cnt     <= '0;
      r_set_cnt     <= '0;
      r_adapt_first <= 1'b0;
      r_clr         <= 1'b0;
      r_por_manual  <= 1'b0;
      r_por_in      <= '0;
      r_thr_lat     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_tmo_err     <= 1'b0;
      r_adpt_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_adapt_first <= (r_state == S_CLEAR);
      r_clr         <= (w_state_nxt == S_CLEAR);
      r_busy        <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_ADAPT) ||
                       (w_state_nxt == S_SETTLE);
      r_done        <= w_lock;
      r_por_manual  <= manual_en;
      r_por_in      <= manual_thr;

      if (w_lock) begin
        r_thr_lat  <= por_out;
        r_adpt_cnt <= r_adpt_cnt + 16'd1;
      end

      if (w_timeout) begin
        r_tmo_err <= 1'b1;
      end else if (w_start_acc) begin
        r_tmo_err <= 1'b0;
      end

      r_tmo_cnt <= ((r_state == S_ADAPT)  && (w_state_nxt == S_ADAPT))  ? w_tmo_sat : '0;
      r_set_cnt <= ((r_state == S_SETTLE) && (w_state_nxt == S_SETTLE)) ?
                   w_set_inc[c_set_w-1:0] : '0;
      r_per_cnt <= ((r_state == S_LOCKED) && (w_state_nxt == S_LOCKED)) ? w_per_sat : '0;
    end
  end

  assign clr        = r_clr;
  assign por_manual = r_por_manual;
  assign por_in     = r_por_in;
  assign thr_lat    = r_thr_lat;
  assign busy       = r_busy;
  assign done       = r_done;
  assign tmo_err    = r_tmo_err;
  assign adpt_cnt   = r_adpt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sig_mag_adpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sig_mag_adpt_ctrl
// Brief   : Scenario bench for sig_mag_adpt_ctrl with a lock-result scoreboard.
// Rev     : 1.0
// ============================================================================
module tb_sig_mag_adpt_ctrl;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        stop;
  logic [31:0] period_cyc;
  logic [23:0] tmo_cyc;
  logic        manual_en;
  logic [12:0] manual_thr;
  logic        adpt_ready;
  logic [12:0] por_out;
  logic        clr;
  logic        por_manual;
  logic [12:0] por_in;
  logic [12:0] thr_lat;
  logic        busy;
  logic        done;
  logic        tmo_err;
  logic [15:0] adpt_cnt;

  sig_mag_adpt_ctrl #(
    .WIDTH(14), .PER_W(32), .TMO_W(24), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .period_cyc(period_cyc), .tmo_cyc(tmo_cyc),
    .manual_en(manual_en), .manual_thr(manual_thr),
    .adpt_ready(adpt_ready), .por_out(por_out),
    .clr(clr), .por_manual(por_manual), .por_in(por_in), .thr_lat(thr_lat),
    .busy(busy), .done(done), .tmo_err(tmo_err), .adpt_cnt(adpt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] thr;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] exp_cnt = 16'd0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          clr_count = 0;
  int          done_count = 0;
  int          last_clr_cyc = 0;
  int          last_done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs clr/done timing and scores every lock against the queue.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (clr === 1'b1) begin
        clr_count    = clr_count + 1;
        last_clr_cyc = cyc;
      end
      if (done === 1'b1) begin
        done_count    = done_count + 1;
        last_done_cyc = cyc;
        n_cmp = n_cmp + 1;
        if (exp_q.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL sb_unexpected_done: done=1 with no lock expected (thr_lat=%h adpt_cnt=%h)",
                   thr_lat, adpt_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          if (thr_lat !== mon_e.thr || adpt_cnt !== mon_e.cnt) begin
            n_err = n_err + 1;
            $display("FAIL sb_lock: thr_lat=%h adpt_cnt=%h expected thr_lat=%h adpt_cnt=%h",
                     thr_lat, adpt_cnt, mon_e.thr, mon_e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [12:0] t);
    exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back('{thr: t, cnt: exp_cnt});
  endtask

  task automatic wait_done(input int prev, input int bound, output int steps, output bit seen);
    seen  = 1'b0;
    steps = 0;
    while (!seen && steps < bound) begin
      step();
      steps++;
      if (done_count != prev) seen = 1'b1;
    end
  endtask

  task automatic wait_clr(input int prev, input int bound, output int steps, output bit seen);
    seen  = 1'b0;
    steps = 0;
    while (!seen && steps < bound) begin
      step();
      steps++;
      if (clr_count != prev) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    period_cyc = '0;
    tmo_cyc    = '0;
    manual_en  = 1'b0;
    manual_thr = '0;
    adpt_ready = 1'b0;
    por_out    = '0;
    repeat (2) step();
    exp_q.delete();
    exp_cnt = 16'd0;
    resetn  = 1'b1;
    step();
  endtask

  task automatic run_lock(input logic [12:0] val, input int ready_at);
    int st;
    bit seen;
    int d0;
    d0 = done_count;
    por_out = val;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (ready_at) step();
    adpt_ready = 1'b1;
    push(val);
    wait_done(d0, 100, st, seen);
    adpt_ready = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL lock_timeout: no done for thr %h within 100 cycles", val);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start = 1'b0; stop = 1'b0; period_cyc = '0; tmo_cyc = '0;
    manual_en = 1'b1; manual_thr = 13'h1abc; adpt_ready = 1'b0; por_out = 13'h0fff;
    repeat (3) step();
    n_cmp++;
    if ({clr, busy, done, tmo_err, por_manual} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: clr/busy/done/tmo_err/por_manual=%b expected 00000",
               {clr, busy, done, tmo_err, por_manual});
    end
    n_cmp++;
    if (por_in !== 13'h0 || thr_lat !== 13'h0) begin
      n_err++;
      $display("FAIL reset_thr: por_in=%h thr_lat=%h expected 0/0", por_in, thr_lat);
    end
    n_cmp++;
    if (adpt_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_cnt: adpt_cnt=%h expected 0000", adpt_cnt);
    end
  endtask

  task automatic test_basic();
    int st;
    bit seen;
    int c0, d0;
    do_reset();
    por_out = 13'h0123;
    c0 = clr_count;
    d0 = done_count;
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (clr !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_clr: clr=%b busy=%b expected 1/1", clr, busy);
    end
    repeat (50) step();
    adpt_ready = 1'b1;
    push(13'h0123);
    wait_done(d0, 100, st, seen);
    adpt_ready = 1'b0;
    n_cmp++;
    if (!seen || (last_done_cyc - last_clr_cyc) != 50 + SETTLE + 1) begin
      n_err++;
      $display("FAIL basic_latency: clr->done=%0d (seen=%0d) expected %0d",
               last_done_cyc - last_clr_cyc, seen, 50 + SETTLE + 1);
    end
    n_cmp++;
    if (clr_count - c0 != 1) begin
      n_err++;
      $display("FAIL basic_clr_count: clr pulses=%0d expected 1", clr_count - c0);
    end
    n_cmp++;
    if (thr_lat !== 13'h0123 || adpt_cnt !== 16'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_locked: thr_lat=%h adpt_cnt=%h busy=%b expected 0123/0001/0",
               thr_lat, adpt_cnt, busy);
    end
  endtask

  task automatic test_timeout();
    int st;
    int d0;
    do_reset();
    tmo_cyc = 24'd100;
    d0 = done_count;
    start = 1'b1;
    step();
    start = 1'b0;
    st = 0;
    while (tmo_err !== 1'b1 && st < 300) begin
      step();
      st++;
    end
    n_cmp++;
    if (tmo_err !== 1'b1 || st != 101) begin
      n_err++;
      $display("FAIL timeout_latency: tmo_err=%b after %0d cycles from clr, expected 1 after 101",
               tmo_err, st);
    end
    n_cmp++;
    if (busy !== 1'b0 || done_count != d0) begin
      n_err++;
      $display("FAIL timeout_idle: busy=%b dones=%0d expected 0/0", busy, done_count - d0);
    end
    repeat (10) step();
    n_cmp++;
    if (tmo_err !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: tmo_err=%b expected 1", tmo_err);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (tmo_err !== 1'b0 || clr !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_restart: tmo_err=%b clr=%b expected 0/1", tmo_err, clr);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    tmo_cyc = '0;
    n_cmp++;
    if (busy !== 1'b0 || clr !== 1'b0) begin
      n_err++;
      $display("FAIL stop_abort: busy=%b clr=%b expected 0/0", busy, clr);
    end
  endtask

  task automatic test_period();
    int st;
    bit seen;
    int d0;
    do_reset();
    period_cyc = 32'd200;
    run_lock(13'h0aaa, 5);
    d0 = last_done_cyc;
    wait_clr(clr_count, 400, st, seen);
    n_cmp++;
    if (!seen || (last_clr_cyc - d0) != 200) begin
      n_err++;
      $display("FAIL period_clr: done->clr=%0d (seen=%0d) expected 200", last_clr_cyc - d0, seen);
    end
    period_cyc = '0;
    repeat (5) step();
    por_out = 13'h1555;
    adpt_ready = 1'b1;
    push(13'h1555);
    wait_done(done_count, 100, st, seen);
    adpt_ready = 1'b0;
    n_cmp++;
    if (!seen || adpt_cnt !== 16'd2 || thr_lat !== 13'h1555) begin
      n_err++;
      $display("FAIL period_second_lock: adpt_cnt=%h thr_lat=%h seen=%0d expected 0002/1555/1",
               adpt_cnt, thr_lat, seen);
    end
    repeat (30) step();
    period_cyc = 32'd10;
    wait_clr(clr_count, 5, st, seen);
    n_cmp++;
    if (!seen || st != 1) begin
      n_err++;
      $display("FAIL period_live_lower: clr after %0d cycles (seen=%0d) expected 1", st, seen);
    end
    period_cyc = '0;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_start_stop();
    int c0, d0;
    do_reset();
    run_lock(13'h0321, 8);
    c0 = clr_count;
    d0 = done_count;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    n_cmp++;
    if (clr !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL startstop_idle: clr=%b busy=%b expected 0/0", clr, busy);
    end
    repeat (5) step();
    n_cmp++;
    if (clr_count != c0 || done_count != d0 || thr_lat !== 13'h0321 || adpt_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL startstop_hold: clrs=%0d dones=%0d thr_lat=%h adpt_cnt=%h expected 0/0/0321/0001",
               clr_count - c0, done_count - d0, thr_lat, adpt_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    bit seen;
    int c0, d0;
    do_reset();
    c0 = clr_count;
    d0 = done_count;
    por_out = 13'h0f0f;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    adpt_ready = 1'b1;
    push(13'h0f0f);
    wait_done(d0, 100, st, seen);
    adpt_ready = 1'b0;
    n_cmp++;
    if (!seen || clr_count - c0 != 1 || (last_done_cyc - last_clr_cyc) != 10 + SETTLE + 1) begin
      n_err++;
      $display("FAIL busy_start_ignored: clrs=%0d clr->done=%0d expected 1/%0d",
               clr_count - c0, last_done_cyc - last_clr_cyc, 10 + SETTLE + 1);
    end
    // ready already high when the sequence starts: honoured only on the 2nd ADAPT cycle
    stop = 1'b1;
    step();
    stop = 1'b0;
    d0 = done_count;
    por_out = 13'h1234;
    adpt_ready = 1'b1;
    push(13'h1234);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(d0, 100, st, seen);
    adpt_ready = 1'b0;
    n_cmp++;
    if (!seen || (last_done_cyc - last_clr_cyc) != 2 + SETTLE + 1) begin
      n_err++;
      $display("FAIL stale_ready: clr->done=%0d (seen=%0d) expected %0d",
               last_done_cyc - last_clr_cyc, seen, 2 + SETTLE + 1);
    end
  endtask

  task automatic test_manual();
    do_reset();
    manual_en  = 1'b1;
    manual_thr = 13'h0400;
    n_cmp++;
    if (por_manual !== 1'b0) begin
      n_err++;
      $display("FAIL manual_latency: por_manual=%b before clock, expected 0", por_manual);
    end
    step();
    n_cmp++;
    if (por_manual !== 1'b1 || por_in !== 13'h0400) begin
      n_err++;
      $display("FAIL manual_idle: por_manual=%b por_in=%h expected 1/0400", por_manual, por_in);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b1 || por_manual !== 1'b1 || por_in !== 13'h0400) begin
      n_err++;
      $display("FAIL manual_adapt: busy=%b por_manual=%b por_in=%h expected 1/1/0400",
               busy, por_manual, por_in);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    run_lock(13'h0abc, 4);
    n_cmp++;
    if (por_manual !== 1'b1 || thr_lat !== 13'h0abc) begin
      n_err++;
      $display("FAIL manual_locked: por_manual=%b thr_lat=%h expected 1/0abc", por_manual, thr_lat);
    end
    manual_en  = 1'b0;
    manual_thr = 13'h0055;
    step();
    n_cmp++;
    if (por_manual !== 1'b0 || por_in !== 13'h0055) begin
      n_err++;
      $display("FAIL manual_off: por_manual=%b por_in=%h expected 0/0055", por_manual, por_in);
    end
  endtask

  task automatic test_reset_mid();
    int st;
    bit seen;
    int c0;
    do_reset();
    manual_en  = 1'b1;
    manual_thr = 13'h0400;
    run_lock(13'h0777, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (clr !== 1'b1) begin
      n_err++;
      $display("FAIL locked_force_readapt: clr=%b expected 1", clr);
    end
    repeat (5) step();
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({clr, busy, done, tmo_err, por_manual} !== 5'b0 || por_in !== 13'h0) begin
      n_err++;
      $display("FAIL async_reset_flags: flags=%b por_in=%h expected 00000/0000",
               {clr, busy, done, tmo_err, por_manual}, por_in);
    end
    n_cmp++;
    if (thr_lat !== 13'h0 || adpt_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset_regs: thr_lat=%h adpt_cnt=%h expected 0000/0000", thr_lat, adpt_cnt);
    end
    c0 = clr_count;
    step();
    manual_en = 1'b0;
    exp_q.delete();
    exp_cnt = 16'd0;
    resetn  = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (clr_count != c0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: clrs=%0d busy=%b expected 0/0", clr_count - c0, busy);
    end
    run_lock(13'h0456, 3);
    n_cmp++;
    if (clr_count - c0 != 1 || (last_done_cyc - last_clr_cyc) != 3 + SETTLE + 1) begin
      n_err++;
      $display("FAIL reset_full_seq: clrs=%0d clr->done=%0d expected 1/%0d",
               clr_count - c0, last_done_cyc - last_clr_cyc, 3 + SETTLE + 1);
    end
    force dut.r_adpt_cnt = 16'hffff;
    #1;
    release dut.r_adpt_cnt;
    exp_cnt = 16'hffff;
    por_out = 13'h0789;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    adpt_ready = 1'b1;
    push(13'h0789);
    wait_done(done_count, 100, st, seen);
    adpt_ready = 1'b0;
    n_cmp++;
    if (!seen || adpt_cnt !== 16'h0000) begin
      n_err++;
      $display("FAIL cnt_wrap: adpt_cnt=%h seen=%0d expected 0000/1", adpt_cnt, seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_period();
    test_start_stop();
    test_back_to_back();
    test_manual();
    test_reset_mid();
    repeat (3) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d locks outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
